// File: rtl/fir_pkg.sv
// Shared widths, FSM state type and saturation helpers for the FIR output-write stage.
package fir_pkg;

    localparam int unsigned IN_W       = 21;
    localparam int unsigned OUT_W      = 16;
    localparam int unsigned ADDR_W     = 13;
    localparam int unsigned CNT_W      = 14;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } wyj_stan_t;

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic nasyc_clamp(input logic signed [IN_W-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    // Clamp a wide signed FIR result into the signed RAM sample range.
    function automatic logic [OUT_W-1:0] nasyc(input logic signed [IN_W-1:0] x);
        if (x > SAT_MAX) begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end else if (x < SAT_MIN) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return x[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with show-ahead head; push into a full FIFO is legal only with a pop.
module fifo_sync #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fir_wyj_zapis.sv
// FIR output stage: saturates results, buffers them and writes them to the sample RAM in order.
module fir_wyj_zapis
    import fir_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       ile_probek,
    input  logic                   wyj_wr,
    input  logic signed [IN_W-1:0] probka_wynik,
    input  logic                   ram_ready,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [OUT_W-1:0]       ram_data,
    output logic                   pracuje,
    output logic                   done,
    output logic                   nasycenie,
    output logic                   przepelnienie
);

    wyj_stan_t         r_stan;
    logic [CNT_W-1:0]  r_target;
    logic [CNT_W-1:0]  r_push_cnt;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pracuje;
    logic              r_done;
    logic              r_nas;
    logic              r_prz;

    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_flush;
    logic              w_full;
    logic              w_empty;
    logic              w_clamp;
    logic [OUT_W-1:0]  w_sample;
    logic [OUT_W-1:0]  w_head;

    assign w_sample   = nasyc(probka_wynik);
    assign w_clamp    = nasyc_clamp(probka_wynik);
    assign w_push_req = wyj_wr && (r_stan == RUN);
    assign w_pop      = ((r_stan == RUN) || (r_stan == DRAIN)) && !w_empty && ram_ready;
    // A full FIFO still takes a result when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_flush    = (r_stan == IDLE) && start;

    fifo_sync #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_sample),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stan     <= IDLE;
            r_target   <= '0;
            r_push_cnt <= '0;
            r_acc_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_addr     <= '0;
            r_pracuje  <= 1'b0;
            r_done     <= 1'b0;
            r_nas      <= 1'b0;
            r_prz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (w_push) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
            if (w_push_req && w_clamp) begin
                r_nas <= 1'b1;
            end
            if (w_drop) begin
                r_prz <= 1'b1;
            end
            case (r_stan)
                IDLE: begin
                    if (start) begin
                        r_target   <= ile_probek;
                        r_push_cnt <= '0;
                        r_acc_cnt  <= '0;
                        r_wr_cnt   <= '0;
                        r_addr     <= '0;
                        r_nas      <= 1'b0;
                        r_prz      <= 1'b0;
                        if (ile_probek == '0) begin
                            r_stan <= DONE;
                            r_done <= 1'b1;
                        end else begin
                            r_stan    <= RUN;
                            r_pracuje <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Dropped results count too, so a stalled RAM cannot hang the run.
                    if (w_push_req) begin
                        r_push_cnt <= r_push_cnt + CNT_W'(1);
                        if (r_push_cnt + CNT_W'(1) == r_target) begin
                            r_stan <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty || (w_pop && (r_wr_cnt + CNT_W'(1) == r_acc_cnt))) begin
                        r_stan    <= DONE;
                        r_done    <= 1'b1;
                        r_pracuje <= 1'b0;
                    end
                end
                DONE: begin
                    r_stan <= IDLE;
                end
                default: begin
                    r_stan <= IDLE;
                end
            endcase
        end
    end

    assign ram_we        = w_pop;
    assign ram_addr      = r_addr;
    assign ram_data      = w_head;
    assign pracuje       = r_pracuje;
    assign done          = r_done;
    assign nasycenie     = r_nas;
    assign przepelnienie = r_prz;

endmodule

// File: tb/tb_fir_wyj_zapis.sv
// Scoreboard bench for fir_wyj_zapis: stimulus queues expected RAM writes, a monitor checks them.
module tb_fir_wyj_zapis;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [13:0]        ile_probek;
    logic               wyj_wr;
    logic signed [20:0] probka_wynik;
    logic               ram_ready;
    logic               ram_we;
    logic [12:0]        ram_addr;
    logic [15:0]        ram_data;
    logic               pracuje;
    logic               done;
    logic               nasycenie;
    logic               przepelnienie;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          last_we_cyc = -100;
    int          done_cyc    = -1;
    logic [12:0] exp_addr [$];
    logic [15:0] exp_data [$];

    fir_wyj_zapis dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ile_probek    (ile_probek),
        .wyj_wr        (wyj_wr),
        .probka_wynik  (probka_wynik),
        .ram_ready     (ram_ready),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .pracuje       (pracuje),
        .done          (done),
        .nasycenie     (nasycenie),
        .przepelnienie (przepelnienie)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every RAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && ram_we) begin
            if (exp_addr.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", ram_addr, ram_data);
            end else begin
                check("ram_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
                check("ram_data", 32'(ram_data), 32'(exp_data.pop_front()));
            end
            last_we_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        ile_probek = 14'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic push_val(input int v, input bit exp_it, input int a, input logic [15:0] d);
        wyj_wr       = 1'b1;
        probka_wynik = 21'(v);
        if (exp_it) begin
            exp_addr.push_back(13'(a));
            exp_data.push_back(d);
        end
        tick();
        wyj_wr = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: got no done within %0d cycles expected done pulse", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_we"},    32'(ram_we), 32'd0);
        check({name, "_addr"},  32'(ram_addr), 32'd0);
        check({name, "_data"},  32'(ram_data), 32'd0);
        check({name, "_prac"},  32'(pracuje), 32'd0);
        check({name, "_done"},  32'(done), 32'd0);
        check({name, "_nas"},   32'(nasycenie), 32'd0);
        check({name, "_prz"},   32'(przepelnienie), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        ile_probek   = '0;
        wyj_wr       = 1'b0;
        probka_wynik = '0;
        ram_ready    = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: three plain results written in order.
        do_start(3);
        check("t1_pracuje", 32'(pracuje), 32'd1);
        push_val(100, 1'b1, 0, 16'h0064);
        push_val(-5,  1'b1, 1, 16'hFFFB);
        push_val(7,   1'b1, 2, 16'h0007);
        wait_done("t1_done", 20);
        check("t1_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
        check("t1_prac_fall", 32'(pracuje), 32'd0);
        check("t1_nas", 32'(nasycenie), 32'd0);
        check("t1_prz", 32'(przepelnienie), 32'd0);
        @(negedge clk);
        check("t1_done_width", 32'(done), 32'd0);
        tick();

        // 2: positive and negative saturation.
        do_start(2);
        push_val(40000,  1'b1, 0, 16'h7FFF);
        push_val(-40000, 1'b1, 1, 16'h8000);
        wait_done("t2_done", 20);
        check("t2_nas", 32'(nasycenie), 32'd1);
        tick();
        tick();
        check("t2_nas_sticky", 32'(nasycenie), 32'd1);

        // 3: RAM stalled for 10 cycles, two of six results dropped.
        ram_ready = 1'b0;
        do_start(6);
        check("t3_nas_clear", 32'(nasycenie), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            push_val(i, i <= 4, i - 1, 16'(i));
        end
        for (int i = 0; i < 3; i++) tick();
        check("t3_prz", 32'(przepelnienie), 32'd1);
        check("t3_prac", 32'(pracuje), 32'd1);
        check("t3_pending", 32'(exp_addr.size()), 32'd4);
        tick();
        ram_ready = 1'b1;
        wait_done("t3_done", 20);
        check("t3_pending_end", 32'(exp_addr.size()), 32'd0);
        check("t3_prz_end", 32'(przepelnienie), 32'd1);
        tick();

        // 4: empty run finishes immediately.
        do_start(0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_prac", 32'(pracuje), 32'd0);
        check("t4_prz_clear", 32'(przepelnienie), 32'd0);
        tick();
        check("t4_done_width", 32'(done), 32'd0);
        tick();

        // 5: reset mid-run with one sample still buffered, then a fresh run from address 0.
        do_start(5);
        push_val(10, 1'b1, 0, 16'h000A);
        push_val(20, 1'b1, 1, 16'h0014);
        tick();
        ram_ready = 1'b0;
        push_val(30, 1'b0, 0, 16'h0000);
        check("t5_addr_pre", 32'(ram_addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        tick();
        rst_n     = 1'b1;
        ram_ready = 1'b1;
        tick();
        do_start(2);
        push_val(7, 1'b1, 0, 16'h0007);
        push_val(8, 1'b1, 1, 16'h0008);
        wait_done("t5_done", 20);
        tick();

        // 6: run longer than the RAM, addresses wrap.
        do_start(8194);
        for (int i = 0; i < 8194; i++) begin
            push_val(i & 16'h3FFF, 1'b1, i % 8192, 16'(i & 16'h3FFF));
        end
        wait_done("t6_done", 20);
        check("t6_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
        check("t6_addr_end", 32'(ram_addr), 32'd2);
        check("t6_pending", 32'(exp_addr.size()), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
